daisychain_host: RTL and testbench
==================================

# daisychain_host

Host-side master for the single-wire daisychain serial link. Accepts one command request at a time on a valid/ready interface and serialises a frame onto the bidirectional `data_inout` line: start bit, command, turnaround, then a data phase. For write commands the host drives the data phase; for read commands it releases the line, samples it and returns the word. It sits between the system-side register logic and the chain of `serial_ctrl` devices.

## Interface
Parameters:
- TURN_CYCLES, 2: cycles between the last command bit and the first data bit.
- GAP_CYCLES, 2: idle cycles, line driven 0, after every frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_inout  inout  1  serial line; host drives it except during read turnaround and read data.
- req_valid  in  1  request present.
- req_ready  out  1  host idle; request accepted on an edge where req_valid && req_ready.
- req_cmd  in  `CMD_LEN  command code (START_RCV_CMD, START_SND_CMD, RESET_CMD, UPDATE_CMD).
- req_wdata  in  `DATA_LEN  word to send for START_RCV_CMD; ignored otherwise.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds a new read word.
- rsp_rdata  out  `DATA_LEN  last word read; holds until next read completes.
- busy  out  1  frame in progress (= !req_ready).

## Operation
- States: IDLE, START, CMD, TURN, WR_DATA, RD_DATA, GAP.
- IDLE: line driven 0; req_ready=1. Accept: latch req_cmd and req_wdata into internal registers, go to START.
- START: 1 cycle, line driven 1 (start bit).
- CMD: `CMD_LEN cycles, command driven MSB first.
- TURN: TURN_CYCLES cycles. START_SND_CMD (device sends): line released (Z). All other commands: line driven 0.
- Data phase by command:
  - START_RCV_CMD: WR_DATA, `DATA_LEN cycles, req_wdata driven MSB first.
  - START_SND_CMD: RD_DATA, `DATA_LEN cycles, line released; each cycle sample data_inout, shift left, insert at LSB. On the last sample the register update goes to rsp_rdata, and rsp_valid pulses in the first GAP cycle.
  - RESET_CMD, UPDATE_CMD, or any unlisted code: no data phase, TURN goes directly to GAP.
- GAP: GAP_CYCLES cycles, line driven 0, then IDLE.
- bit counter: one shared counter, width $clog2 of max(`DATA_LEN, `CMD_LEN, TURN_CYCLES, GAP_CYCLES) + 1. Cleared on every state entry; the state exits when the count equals its length minus 1.
- Output-enable and output-data are registered (no combinational path to the pad). The line is never left floating outside TURN and RD_DATA of a read frame.

## Timing
- Reset values: state IDLE, line driven 0, req_ready 1, busy 0, rsp_valid 0, rsp_rdata 0. Reset is asynchronous and aborts any frame immediately, with the line driven 0. No rsp_valid is issued for an aborted read.
- The start bit appears in the cycle after the accept edge.
- Frame length in cycles, start bit through last GAP cycle:
  - write: 1 + `CMD_LEN + TURN_CYCLES + `DATA_LEN + GAP_CYCLES.
  - read: the same as write.
  - command-only: 1 + `CMD_LEN + TURN_CYCLES + GAP_CYCLES.
- req_ready drops on the accept edge and rises on entry to IDLE. The minimum spacing between start bits is frame length + 1.
- req_valid held high in IDLE produces back-to-back frames separated by exactly one IDLE cycle.
- Read latency: rsp_valid rises on the edge after the last RD_DATA sample cycle.
- Changes to req_cmd or req_wdata after acceptance have no effect.

## Structure
- Shared package/includes.svh additions:
  - `host_state_t` enum.
  - the command code constants, shared with `serial_ctrl`.
  - `DATA_LEN and `CMD_LEN, already defined there.
- One sub-module, `host_shifter`: a `DATA_LEN-bit register with parallel load, shift-out MSB and shift-in LSB, used for both wdata and rdata. The command is shifted from a local `CMD_LEN register.

## Test plan
- Reset then idle for 20 cycles -> line 0, req_ready 1, rsp_valid never high.
- Write: DATA_LEN=8, req_cmd=START_RCV_CMD, req_wdata=8'hA5 -> line sequence is start 1, cmd MSB first, TURN 0s, then 1,0,1,0,0,1,0,1, then GAP 0s. req_ready low for exactly the write frame length + 1 edge.
- Read: START_SND_CMD with bench driving 8'h3C during RD_DATA -> host output-enable low through TURN+RD_DATA, rsp_rdata=8'h3C, single rsp_valid pulse in first GAP cycle.
- UPDATE_CMD with req_valid held high and a second request queued -> command-only frame, one IDLE cycle, then the second start bit. The first frame has no data phase.
- reset asserted mid-RD_DATA -> line driven 0 at once, state IDLE, no rsp_valid, rsp_rdata=0. The next request runs normally.
- Unlisted command code 'b0 -> treated as command-only frame, returns to IDLE.

Source files
------------

// File: rtl/daisychain_host_pkg.sv
// Shared definitions for the daisychain host: word sizes, command codes and host FSM states.
package daisychain_host_pkg;

    localparam int unsigned DATA_LEN = 8;
    localparam int unsigned CMD_LEN  = 4;

    // Command codes shared with serial_ctrl; code 0 is deliberately unassigned
    localparam logic [CMD_LEN-1:0] RESET_CMD     = 4'h1;
    localparam logic [CMD_LEN-1:0] START_RCV_CMD = 4'h2;
    localparam logic [CMD_LEN-1:0] START_SND_CMD = 4'h3;
    localparam logic [CMD_LEN-1:0] UPDATE_CMD    = 4'h4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        TURN,
        WR_DATA,
        RD_DATA,
        GAP
    } host_state_t;

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/daisychain_host_if.sv
// Request/response handshake between system register logic (master) and the host (slave).
interface daisychain_host_if;

    logic                                      req_valid;
    logic                                      req_ready;
    logic [daisychain_host_pkg::CMD_LEN-1:0]   req_cmd;
    logic [daisychain_host_pkg::DATA_LEN-1:0]  req_wdata;
    logic                                      rsp_valid;
    logic [daisychain_host_pkg::DATA_LEN-1:0]  rsp_rdata;
    logic                                      busy;

    modport master (
        output req_valid, req_cmd, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_cmd, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/daisychain_host_shifter.sv
// Data word register: parallel load, MSB-first shift out, LSB shift in (shared by write and read).
module host_shifter
    import daisychain_host_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DATA_LEN-1:0] load_data,
    input  logic                shift_en,
    input  logic                shift_in,
    output logic [DATA_LEN-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[DATA_LEN-2:0], shift_in};
        end
    end

endmodule

// File: rtl/daisychain_host.sv
// Host master for the single-wire daisychain link: frames one request at a time onto data_inout.
module daisychain_host
    import daisychain_host_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               data_inout,
    daisychain_host_if.slave  bus
);

    localparam int unsigned CNT_MAX = max_of4(DATA_LEN, CMD_LEN, TURN_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    host_state_t         state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                last;
    logic                accept;
    logic [CMD_LEN-1:0]  cmd_q;
    logic [CMD_LEN-1:0]  cmd_sr;
    logic [DATA_LEN-1:0] shift_q;
    logic                shift_en;
    logic                shift_in;
    logic                rd_done;
    logic                line_oe, line_oe_n;
    logic                line_d, line_d_n;
    logic                req_ready_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [DATA_LEN-1:0] rsp_rdata_q;

    function automatic int unsigned state_len(input host_state_t s);
        case (s)
            CMD:              return CMD_LEN;
            TURN:             return TURN_CYCLES;
            WR_DATA, RD_DATA: return DATA_LEN;
            GAP:              return GAP_CYCLES;
            default:          return 1;
        endcase
    endfunction

    assign data_inout = line_oe ? line_d : 1'bz;

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    host_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (bus.req_wdata),
        .shift_en  (shift_en),
        .shift_in  (shift_in),
        .q         (shift_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state plus the pad value for the coming cycle, so the pad registers align with state
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        accept    = 1'b0;
        line_oe_n = 1'b1;
        line_d_n  = 1'b0;
        last      = (cnt == CNT_W'(state_len(state) - 1));
        shift_en  = (state == WR_DATA) || (state == RD_DATA);
        shift_in  = (state == RD_DATA) && data_inout;
        rd_done   = (state == RD_DATA) && last;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_n = START;
                end
            end
            START:   if (last) state_n = CMD;
            CMD:     if (last) state_n = TURN;
            TURN: begin
                if (last) begin
                    if (cmd_q == START_RCV_CMD)      state_n = WR_DATA;
                    else if (cmd_q == START_SND_CMD) state_n = RD_DATA;
                    else                             state_n = GAP;
                end
            end
            WR_DATA: if (last) state_n = GAP;
            RD_DATA: if (last) state_n = GAP;
            GAP:     if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n != state) cnt_n = '0;

        // Shift registers advance on the same edge, so mid-phase the next bit sits one below MSB
        case (state_n)
            START:   line_d_n  = 1'b1;
            CMD:     line_d_n  = (state == CMD) ? cmd_sr[CMD_LEN-2] : cmd_sr[CMD_LEN-1];
            TURN:    line_oe_n = (cmd_q != START_SND_CMD);
            WR_DATA: line_d_n  = (state == WR_DATA) ? shift_q[DATA_LEN-2] : shift_q[DATA_LEN-1];
            RD_DATA: line_oe_n = 1'b0;
            default: line_d_n  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q       <= '0;
            cmd_sr      <= '0;
            line_oe     <= 1'b1;
            line_d      <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                cmd_q  <= bus.req_cmd;
                cmd_sr <= bus.req_cmd;
            end else if (state == CMD) begin
                cmd_sr <= {cmd_sr[CMD_LEN-2:0], 1'b0};
            end
            line_oe     <= line_oe_n;
            line_d      <= line_d_n;
            req_ready_q <= (state_n == IDLE);
            busy_q      <= (state_n != IDLE);
            rsp_valid_q <= rd_done;
            if (rd_done) rsp_rdata_q <= {shift_q[DATA_LEN-2:0], data_inout};
        end
    end

endmodule

// File: tb/tb_daisychain_host.sv
// Randomised scoreboard bench for daisychain_host; an open-drain device model answers reads.
module tb_daisychain_host;
    import daisychain_host_pkg::*;

    localparam int unsigned TURN     = 2;
    localparam int unsigned GAPC     = 2;
    localparam int          RD_START = 1 + CMD_LEN + TURN;

    typedef struct {
        logic [CMD_LEN-1:0]  cmd;
        logic [DATA_LEN-1:0] wdata;
        logic [DATA_LEN-1:0] rword;
        bit                  b2b;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dev_low = 1'b0;
    wire  data_inout;

    always #5 clk = ~clk;

    pullup (data_inout);
    assign data_inout = (dev_low && !reset) ? 1'b0 : 1'bz;

    daisychain_host_if bus();

    daisychain_host #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_inout (data_inout),
        .bus        (bus)
    );

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    frame_t exp_q[$];
    frame_t cur;
    bit     mon_active = 0;
    int     mon_pos = 0;
    int     last_start = 0;
    int     last_len = 0;

    function automatic bit is_read(input logic [CMD_LEN-1:0] c);
        return c == START_SND_CMD;
    endfunction

    function automatic bit has_data(input logic [CMD_LEN-1:0] c);
        return (c == START_RCV_CMD) || (c == START_SND_CMD);
    endfunction

    function automatic int flen(input logic [CMD_LEN-1:0] c);
        return 1 + CMD_LEN + TURN + (has_data(c) ? DATA_LEN : 0) + GAPC;
    endfunction

    // Expected pad level at frame cycle k: -1 = don't care (device drives)
    function automatic int exp_line(input frame_t f, input int k);
        int j;
        j = k;
        if (j == 0) return 1;
        j = j - 1;
        if (j < CMD_LEN) return int'(f.cmd[CMD_LEN-1-j]);
        j = j - CMD_LEN;
        if (j < TURN) return is_read(f.cmd) ? 1 : 0;
        j = j - TURN;
        if (has_data(f.cmd)) begin
            if (j < DATA_LEN) return is_read(f.cmd) ? -1 : int'(f.wdata[DATA_LEN-1-j]);
        end
        return 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: follows frames on the pad and checks them against the queued requests
    always @(negedge clk) begin
        int  e;
        bit  rv;
        cyc++;
        if (reset) begin
            mon_active = 0;
            dev_low    = 0;
        end else begin
            if (!mon_active) begin
                if (data_inout == 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got start bit expected idle (cycle %0d)", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.b2b) chk("b2b_spacing", cyc - last_start, last_len + 1);
                        last_start = cyc;
                        last_len   = flen(cur.cmd);
                        mon_active = 1;
                        mon_pos    = 0;
                    end
                end else begin
                    chk("idle_ready", bus.req_ready, 1);
                    chk("idle_busy", bus.busy, 0);
                    chk("idle_rsp_valid", bus.rsp_valid, 0);
                end
            end
            if (mon_active) begin
                e = exp_line(cur, mon_pos);
                if (e >= 0) chk("line", data_inout, e);
                chk("frame_ready", bus.req_ready, 0);
                chk("frame_busy", bus.busy, 1);
                rv = is_read(cur.cmd) && (mon_pos == RD_START + DATA_LEN);
                chk("rsp_valid", bus.rsp_valid, rv);
                if (rv) chk("rsp_rdata", bus.rsp_rdata, cur.rword);
                if (is_read(cur.cmd) && mon_pos >= RD_START && mon_pos < RD_START + DATA_LEN)
                    dev_low = !cur.rword[DATA_LEN-1-(mon_pos-RD_START)];
                else
                    dev_low = 0;
                mon_pos++;
                if (mon_pos == flen(cur.cmd)) mon_active = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [CMD_LEN-1:0] c, input logic [DATA_LEN-1:0] wd,
                         input logic [DATA_LEN-1:0] rw, input bit b2b);
        frame_t f;
        int     n;
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_wdata = wd;
        f.cmd = c; f.wdata = wd; f.rword = rw; f.b2b = b2b;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
        end
        exp_q.push_back(f);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_cmd   = CMD_LEN'($urandom);
        bus.req_wdata = DATA_LEN'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int                  n;
        int                  gap;
        int                  sel;
        logic [CMD_LEN-1:0]  c;

        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_line", data_inout, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        issue(START_RCV_CMD, 8'hA5, 8'h00, 0);
        wait_idle();
        issue(START_SND_CMD, 8'h00, 8'h3C, 0);
        wait_idle();
        chk("rdata_hold", bus.rsp_rdata, 8'h3C);

        issue(UPDATE_CMD, 8'hFF, 8'h00, 0);
        issue(START_RCV_CMD, 8'h5A, 8'h00, 1);
        wait_idle();
        issue(4'h0, 8'h81, 8'h00, 0);
        wait_idle();

        // Abort a read in the middle of its data phase
        issue(START_SND_CMD, 8'h00, 8'h96, 0);
        n = 0;
        while (!(mon_active && mon_pos == RD_START + 4) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL rd_wait_timeout: got no read data phase expected one");
        end
        reset = 1'b1;
        #1;
        chk("abort_line", data_inout, 0);
        chk("abort_ready", bus.req_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        issue(START_RCV_CMD, 8'hC3, 8'h00, 0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       c = RESET_CMD;
                1:       c = START_RCV_CMD;
                2:       c = START_SND_CMD;
                3:       c = UPDATE_CMD;
                4:       c = START_SND_CMD;
                default: c = CMD_LEN'($urandom);
            endcase
            issue(c, DATA_LEN'($urandom), DATA_LEN'($urandom), (gap == 0) && (i > 0));
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
